ring_rr_arbiter: RTL

- Round-robin arbiter that shares one resource between N requesters.
- Priority is tracked by a one-hot pointer that rotates like a ring counter.
- Grant is one-hot and registered, with lock/hold semantics and a bounded hold time so no requester can starve the others.
- Sits in front of a shared datapath, for example the ring counter's load/config path, and sequences which client owns it.

---
 rtl/ring_rr_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a rotating one-hot priority pointer,
// registered one-hot grant, hold/lock semantics and a bounded hold time.
module ring_rr_arbiter #(
   parameter int N        = 8,
   parameter int HOLD_MAX = 16,
   parameter int IDW      = 3,
   parameter int HCW      = 5
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   input  logic [N-1:0]   req,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] gnt_id,
   output logic           gnt_valid,
   output logic           preempt,
   output logic [N-1:0]   ptr
);

   typedef enum logic {
      S_IDLE,
      S_GRANT
   } state_t;

   localparam bit             LP_UNLIM = (HOLD_MAX == 0);
   localparam logic [HCW-1:0] LP_HLIM  =
      LP_UNLIM ? {HCW{1'b1}} : HCW'(HOLD_MAX - 1);
   localparam logic [IDW:0]   LP_N     = (IDW+1)'(N);
   localparam logic [N-1:0]   LP_ONE   = {{(N-1){1'b0}}, 1'b1};

   state_t         r_state;
   state_t         w_state;
   logic [N-1:0]   r_gnt;
   logic [N-1:0]   w_gnt;
   logic [IDW-1:0] r_gnt_id;
   logic [IDW-1:0] w_gnt_id;
   logic           r_gnt_valid;
   logic           r_preempt;
   logic           w_preempt;
   logic [N-1:0]   r_ptr;
   logic [N-1:0]   w_ptr;
   logic [HCW-1:0] r_hold;
   logic [HCW-1:0] w_hold;

   logic [N-1:0]   w_req_m;
   logic [N-1:0]   w_rot;
   logic [IDW-1:0] w_pidx;
   logic [IDW-1:0] w_k;
   logic [IDW:0]   w_sum;
   logic [IDW-1:0] w_win;
   logic           w_found;
   logic           w_own_req;
   logic           w_hold_ok;
   logic           w_issue;
   logic [IDW-1:0] w_issue_id;

   function automatic logic [N-1:0] f_next_oh(
      input logic [IDW-1:0] i_id
   );
      if (int'(i_id) == N - 1)
         return LP_ONE;
      else
         return LP_ONE << (i_id + 1'b1);
   endfunction

   // The current owner is masked out so a preempted owner loses the scan;
   // on release its request is already low, so the mask is harmless there.
   assign w_req_m   = req & ~r_gnt;
   assign w_found   = |w_req_m;
   assign w_own_req = |(req & r_gnt);
   assign w_hold_ok = LP_UNLIM || (r_hold < LP_HLIM);

   always_comb begin
      w_pidx = '0;
      for (int i = 0; i < N; i++)
         if (r_ptr[i]) w_pidx = IDW'(i);
   end

   always_comb begin
      w_rot = N'({w_req_m, w_req_m} >> w_pidx);
      w_k   = '0;
      for (int i = N - 1; i >= 0; i--)
         if (w_rot[i]) w_k = IDW'(i);
   end

   assign w_sum = {1'b0, w_pidx} + {1'b0, w_k};
   assign w_win = (w_sum >= LP_N) ? IDW'(w_sum - LP_N)
                                  : w_sum[IDW-1:0];

   always_comb begin
      w_state    = r_state;
      w_gnt      = r_gnt;
      w_gnt_id   = r_gnt_id;
      w_ptr      = r_ptr;
      w_hold     = r_hold;
      w_preempt  = 1'b0;
      w_issue    = 1'b0;
      w_issue_id = w_win;
      unique case (r_state)
         S_IDLE: begin
            if (en && w_found) w_issue = 1'b1;
         end
         S_GRANT: begin
            if (!w_own_req) begin
               if (en && w_found) begin
                  w_issue = 1'b1;
               end else begin
                  w_state  = S_IDLE;
                  w_gnt    = '0;
                  w_gnt_id = '0;
               end
            end else if (w_hold_ok) begin
               if (r_hold != {HCW{1'b1}})
                  w_hold = r_hold + 1'b1;
            end else begin
               w_preempt = 1'b1;
               if (en && w_found) begin
                  w_issue = 1'b1;
               end else if (en) begin
                  w_issue    = 1'b1;
                  w_issue_id = r_gnt_id;
               end else begin
                  w_state  = S_IDLE;
                  w_gnt    = '0;
                  w_gnt_id = '0;
               end
            end
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase
      if (w_issue) begin
         w_state  = S_GRANT;
         w_gnt    = LP_ONE << w_issue_id;
         w_gnt_id = w_issue_id;
         w_ptr    = f_next_oh(w_issue_id);
         w_hold   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_gnt       <= '0;
         r_gnt_id    <= '0;
         r_gnt_valid <= 1'b0;
         r_preempt   <= 1'b0;
         r_ptr       <= LP_ONE;
         r_hold      <= '0;
      end else begin
         r_state     <= w_state;
         r_gnt       <= w_gnt;
         r_gnt_id    <= w_gnt_id;
         r_gnt_valid <= |w_gnt;
         r_preempt   <= w_preempt;
         r_ptr       <= w_ptr;
         r_hold      <= w_hold;
      end
   end

   assign gnt       = r_gnt;
   assign gnt_id    = r_gnt_id;
   assign gnt_valid = r_gnt_valid;
   assign preempt   = r_preempt;
   assign ptr       = r_ptr;

endmodule
